// File: rtl/ntt_op_scheduler.sv
// Round-robin command queue and issue sequencer that shares one NTT/INTT/PWM
// control FSM among NREQ clients, with a per-op watchdog and completion reporting.
module ntt_op_scheduler #(
  parameter int NREQ   = 4,
  parameter int QDEPTH = 4,
  parameter int GAP    = 2,
  parameter int TO_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [2*NREQ-1:0]         req_opcode,
  output logic [NREQ-1:0]           req_ready,
  output logic [1:0]                fsm_opcode,
  output logic                      fsm_start,
  input  logic                      fsm_finish,
  output logic                      done_valid,
  output logic [$clog2(NREQ)-1:0]   done_id,
  output logic [1:0]                done_opcode,
  output logic                      done_err,
  output logic                      err,
  input  logic                      err_clr,
  output logic                      busy,
  output logic [$clog2(QDEPTH):0]   q_count
);

  localparam int IDW = $clog2(NREQ);
  localparam int QAW = $clog2(QDEPTH);
  localparam int GCW = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [1:0]      OP_NTT  = 2'd0;
  localparam logic [QAW:0]    Q_FULL  = (QAW+1)'(QDEPTH);
  localparam logic [GCW-1:0]  GAP_END = GCW'(GAP - 1);
  localparam logic [TO_W-1:0] WD_LAST = {{(TO_W-1){1'b1}}, 1'b0};

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_DONE,
    S_GAP
  } state_t;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [1:0]     op;
  } q_entry_t;

  state_t          state;
  state_t          state_next;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  grant_id;
  logic            grant_any;
  logic [1:0]      grant_op;
  logic            push;
  logic            q_pop;
  q_entry_t        q_mem [QDEPTH];
  q_entry_t        q_head;
  logic [QAW-1:0]  wr_ptr;
  logic [QAW-1:0]  rd_ptr;
  logic [IDW-1:0]  cur_id;
  logic [TO_W-1:0] wd;
  logic            wd_timeout;
  logic [GCW-1:0]  gap_cnt;
  logic            start_d;
  logic            done_d;
  logic            wait_exit;
  logic            timeout_hit;

  // Round-robin arbiter: first valid client at or above rr_ptr, wrapping.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no latch is inferred.
    req_ready = '0;
    grant_any = 1'b0;
    grant_id  = '0;
    if (q_count != Q_FULL) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!grant_any && req_valid[(int'(rr_ptr) + i) % NREQ]) begin
          grant_any = 1'b1;
          grant_id  = IDW'((int'(rr_ptr) + i) % NREQ);
        end
      end
      req_ready[grant_id] = grant_any;
    end
  end

  assign grant_op   = req_opcode[2*int'(grant_id) +: 2];
  assign push       = |(req_valid & req_ready);
  assign q_head     = q_mem[rd_ptr];
  assign wd_timeout = (wd == WD_LAST);

  // NOTE: the queue storage is not reset; the pointers and q_count alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) q_mem[wr_ptr] <= {grant_id, grant_op};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_count <= '0;
      rr_ptr  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + QAW'(1);
        rr_ptr <= IDW'((int'(grant_id) + 1) % NREQ);
      end
      if (q_pop) rd_ptr <= rd_ptr + QAW'(1);
      case ({push, q_pop})
        2'b10:   q_count <= q_count + (QAW+1)'(1);
        2'b01:   q_count <= q_count - (QAW+1)'(1);
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (q_count != '0) state_next = S_LOAD;
      S_LOAD:  state_next = S_ISSUE;
      S_ISSUE: state_next = S_WAIT;
      S_WAIT:  if (fsm_finish || wd_timeout) state_next = S_DONE;
      S_DONE:  state_next = S_GAP;
      S_GAP:   if (gap_cnt == GAP_END) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // A finish arriving together with the timeout counts as a normal completion.
  always_comb begin
    q_pop       = (state == S_LOAD);
    start_d     = (state_next == S_ISSUE);
    done_d      = (state_next == S_DONE);
    wait_exit   = (state == S_WAIT) && (state_next == S_DONE);
    timeout_hit = wait_exit && !fsm_finish;
    busy        = (state != S_IDLE) || (q_count != '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_opcode  <= OP_NTT;
      fsm_start   <= 1'b0;
      cur_id      <= '0;
      done_valid  <= 1'b0;
      done_id     <= '0;
      done_opcode <= '0;
      done_err    <= 1'b0;
      err         <= 1'b0;
      wd          <= '0;
      gap_cnt     <= '0;
    end else begin
      fsm_start  <= start_d;
      done_valid <= done_d;
      // fsm_opcode only moves here, so it holds across start and until finish.
      if (q_pop) begin
        fsm_opcode <= q_head.op;
        cur_id     <= q_head.id;
      end
      if (wait_exit) begin
        done_id     <= cur_id;
        done_opcode <= fsm_opcode;
        done_err    <= timeout_hit;
      end
      if (timeout_hit)  err <= 1'b1;
      else if (err_clr) err <= 1'b0;
      if (state == S_ISSUE)     wd <= '0;
      else if (state == S_WAIT) wd <= wd + TO_W'(1);
      if (state == S_DONE)     gap_cnt <= '0;
      else if (state == S_GAP) gap_cnt <= gap_cnt + GCW'(1);
    end
  end

endmodule

// File: tb/tb_ntt_op_scheduler.sv
// Scoreboard bench for ntt_op_scheduler: directed requests push expected issue
// and completion records; a negedge monitor pops and compares them.
module tb_ntt_op_scheduler;

  localparam int NREQ   = 4;
  localparam int QDEPTH = 4;
  localparam int GAP    = 2;
  localparam int TO_W   = 6;
  localparam int TO_CYC = (1 << TO_W) - 1;

  localparam logic [1:0] OP_NTT  = 2'd0;
  localparam logic [1:0] OP_INTT = 2'd1;
  localparam logic [1:0] OP_PWM0 = 2'd2;
  localparam logic [1:0] OP_PWM1 = 2'd3;

  typedef struct packed {
    logic [1:0] id;
    logic [1:0] op;
    logic       err;
  } done_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req_valid = '0;
  logic [7:0] req_opcode;
  logic [3:0] req_ready;
  logic [1:0] fsm_opcode;
  logic       fsm_start;
  logic       fsm_finish = 1'b0;
  logic       done_valid;
  logic [1:0] done_id;
  logic [1:0] done_opcode;
  logic       done_err;
  logic       err;
  logic       err_clr = 1'b0;
  logic       busy;
  logic [2:0] q_count;

  logic [1:0] op_tab [4] = '{OP_NTT, OP_INTT, OP_PWM0, OP_PWM1};
  assign req_opcode = {op_tab[3], op_tab[2], op_tab[1], op_tab[0]};

  logic [1:0] exp_start [$];
  done_t      exp_done  [$];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int starts_seen = 0;
  int starts_used = 0;
  int last_start_cyc = 0;

  ntt_op_scheduler #(
    .NREQ(NREQ), .QDEPTH(QDEPTH), .GAP(GAP), .TO_W(TO_W)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_opcode(req_opcode), .req_ready(req_ready),
    .fsm_opcode(fsm_opcode), .fsm_start(fsm_start), .fsm_finish(fsm_finish),
    .done_valid(done_valid), .done_id(done_id), .done_opcode(done_opcode),
    .done_err(done_err), .err(err), .err_clr(err_clr),
    .busy(busy), .q_count(q_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every start and every completion must match the next expected record.
  always @(negedge clk) begin
    if (rst) begin
      if (fsm_start) begin
        starts_seen++;
        last_start_cyc = cyc;
        check("start_expected", exp_start.size() != 0, 1);
        if (exp_start.size() != 0) check("start_opcode", fsm_opcode, exp_start.pop_front());
      end
      if (done_valid) begin
        check("done_expected", exp_done.size() != 0, 1);
        if (exp_done.size() != 0) check("done_record", {done_id, done_opcode, done_err}, exp_done.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_op(input int id, input logic e);
    exp_start.push_back(op_tab[id]);
    exp_done.push_back({2'(id), op_tab[id], e});
  endtask

  // Requests the clients in vld, which must be granted in ascending client order.
  task automatic sweep(input logic [3:0] vld, input logic [3:0] err_mask);
    logic [3:0] rem = vld;
    for (int k = 0; k < NREQ; k++) begin
      if (vld[k]) begin
        req_valid = rem;
        #1 check("grant", req_ready, 1 << k);
        expect_op(k, err_mask[k]);
        tick();
        rem[k] = 1'b0;
      end
    end
    req_valid = '0;
  endtask

  task automatic take_start(output int c);
    int n = 0;
    while (starts_seen <= starts_used && n < 200) begin
      tick();
      n++;
    end
    check("start_arrived", starts_seen > starts_used, 1);
    starts_used++;
    c = last_start_cyc;
  endtask

  task automatic run_op(input int lat, output int c_start, output int c_done);
    take_start(c_start);
    while (cyc < c_start + lat) tick();
    fsm_finish = 1'b1;
    tick();
    fsm_finish = 1'b0;
    check("done_after_finish", done_valid, 1);
    c_done = cyc;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 300) begin
      tick();
      n++;
    end
    check("idle_reached", busy, 0);
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    exp_start.delete();
    exp_done.delete();
    starts_used = starts_seen;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int c0, s, d, prev;

    // Reset values
    repeat (3) tick();
    rst = 1'b1;
    #1;
    check("rst_fsm_opcode", fsm_opcode, OP_NTT);
    check("rst_fsm_start", fsm_start, 0);
    check("rst_done_valid", done_valid, 0);
    check("rst_done_id", done_id, 0);
    check("rst_done_opcode", done_opcode, 0);
    check("rst_done_err", done_err, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    check("rst_q_count", q_count, 0);
    check("rst_req_ready", req_ready, 0);

    // 1: single NTT from client 2, finish 40 cycles after start
    tick();
    op_tab[2] = OP_NTT;
    c0 = cyc;
    sweep(4'b0100, 4'b0000);
    op_tab[2] = OP_PWM0;
    #1 check("t1_q_count_c1", q_count, 1);
    tick();
    check("t1_busy_load", busy, 1);
    run_op(40, s, d);
    check("t1_start_latency", s - c0, 3);
    check("t1_done_latency", d - s, 41);
    wait_idle();

    // 2: all four clients from pointer 0, completions in grant order
    reset_dut();
    c0 = cyc;
    sweep(4'b1111, 4'b0000);
    prev = 0;
    for (int k = 0; k < NREQ; k++) begin
      run_op(5 + k, s, d);
      if (k == 0) check("t2_first_start", s - c0, 3);
      else        check("t2_gap", s - prev, GAP + 3);
      prev = d;
    end
    wait_idle();

    // 3: queue full while an op waits; refill right after the LOAD pop
    sweep(4'b1111, 4'b0000);
    req_valid = 4'b0001;
    #1 check("t3_grant_refill", req_ready, 4'b0001);
    expect_op(0, 1'b0);
    tick();
    req_valid = 4'b1111;
    #1;
    check("t3_full_count", q_count, 4);
    check("t3_full_ready", req_ready, 0);
    run_op(4, s, d);
    for (int i = 0; i < GAP + 2; i++) begin
      tick();
      check("t3_hold_ready", req_ready, 0);
      check("t3_hold_count", q_count, 4);
    end
    tick();
    check("t3_issue_count", q_count, 3);
    check("t3_issue_ready", req_ready, 4'b0010);
    check("t3_issue_start", fsm_start, 1);
    expect_op(1, 1'b0);
    tick();
    check("t3_refilled_count", q_count, 4);
    check("t3_refilled_ready", req_ready, 0);
    req_valid = '0;
    for (int k = 0; k < 5; k++) run_op(3, s, d);
    wait_idle();

    // 4: watchdog timeout on client 2, err_clr loses to the set, then client 3 runs
    sweep(4'b1100, 4'b0100);
    take_start(s);
    while (cyc < s + TO_CYC) tick();
    check("t4_no_early_done", done_valid, 0);
    check("t4_err_before", err, 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("t4_timeout_done", done_valid, 1);
    check("t4_done_err", done_err, 1);
    check("t4_err_set_wins", err, 1);
    d = cyc;
    tick();
    check("t4_err_sticky", err, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("t4_err_cleared", err, 0);
    prev = d;
    run_op(3, s, d);
    check("t4_next_issue", s - prev, GAP + 3);
    check("t4_err_after_ok", err, 0);
    wait_idle();

    // 5: finish in the timeout cycle wins; stray finish while idle is ignored
    sweep(4'b0001, 4'b0000);
    run_op(TO_CYC, s, d);
    check("t5_done_latency", d - s, TO_CYC + 1);
    check("t5_err_unchanged", err, 0);
    wait_idle();
    fsm_finish = 1'b1;
    tick();
    fsm_finish = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("t5_stray_no_done", done_valid, 0);
      check("t5_stray_idle", busy, 0);
      tick();
    end

    // 6: reset during WAIT with two ops queued
    sweep(4'b1110, 4'b0000);
    repeat (3) tick();
    check("t6_pre_count", q_count, 2);
    check("t6_pre_opcode", fsm_opcode, OP_INTT);
    rst = 1'b0;
    #1;
    check("t6_rst_count", q_count, 0);
    check("t6_rst_opcode", fsm_opcode, OP_NTT);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_done", done_valid, 0);
    exp_start.delete();
    exp_done.delete();
    starts_used = starts_seen;
    repeat (2) tick();
    rst = 1'b1;
    repeat (20) tick();
    check("t6_post_busy", busy, 0);
    check("t6_post_count", q_count, 0);
    check("t6_no_restart", starts_seen - starts_used, 0);

    check("pending_starts", exp_start.size(), 0);
    check("pending_dones", exp_done.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
